// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR coefficient loader and its bank.
package fir_pkg;
  localparam int FILTER_BITS_DEF = 12;
  localparam int FILTER_TAPS_DEF = 32;
  localparam int COUNT_BITS_DEF  = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ARMED} loader_state_t;

  typedef logic [FILTER_BITS_DEF-1:0] coef_t;
endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage: shadow is written one tap at a time,
// and swap copies the whole shadow into the active bank in one edge.
module fir_coef_bank #(
  parameter int BITS  = 12,
  parameter int TAPS  = 32,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [BITS-1:0]            wdata,
  input  logic                       swap,
  output logic [TAPS-1:0][BITS-1:0]  active
);
  logic [TAPS-1:0][BITS-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (we)   shadow[widx] <= wdata;
      if (swap) active       <= shadow;
    end
  end
endmodule

// File: rtl/fir_coeff_loader.sv
// Streams a coefficient set into a shadow bank and swaps it into the active
// bank on a sample strobe, so no filter output mixes old and new taps.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int FILTER_BITS = FILTER_BITS_DEF,
  parameter int FILTER_TAPS = FILTER_TAPS_DEF,
  parameter int COUNT_BITS  = COUNT_BITS_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   coef_valid,
  output logic                                   coef_ready,
  input  logic [FILTER_BITS-1:0]                 coef_data,
  input  logic                                   coef_last,
  input  logic                                   sample_strobe,
  output logic [FILTER_TAPS-1:0][FILTER_BITS-1:0] filter_coefficients,
  output logic                                   busy,
  output logic                                   swap_done,
  output logic                                   load_error,
  output logic [COUNT_BITS-1:0]                  swap_count
);
  localparam int IDX_W = $clog2(FILTER_TAPS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FILTER_TAPS - 1);

  loader_state_t    state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, widx;
  logic             accept, we, swap, err_nxt;

  assign accept = coef_valid && coef_ready;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    err_nxt    = 1'b0;
    swap       = 1'b0;
    we         = 1'b0;
    widx       = idx;
    coef_ready = (state != ARMED);
    busy       = (state != IDLE);
    case (state)
      IDLE: if (accept) begin
        we   = 1'b1;
        widx = '0;
        if (coef_last) err_nxt = 1'b1;
        else begin
          idx_nxt   = IDX_W'(1);
          state_nxt = LOAD;
        end
      end
      LOAD: if (accept) begin
        we = 1'b1;
        if (idx == IDX_MAX) begin
          // Full set received: a trailing last arms, otherwise flush the overrun.
          idx_nxt   = '0;
          state_nxt = coef_last ? ARMED : DRAIN;
          err_nxt   = !coef_last;
        end else if (coef_last) begin
          idx_nxt   = '0;
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      DRAIN: if (accept && coef_last) state_nxt = IDLE;
      ARMED: if (sample_strobe) begin
        swap      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      load_error <= 1'b0;
      swap_done  <= 1'b0;
      swap_count <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      load_error <= err_nxt;
      swap_done  <= swap;
      swap_count <= swap_count + COUNT_BITS'(swap);
    end
  end

  fir_coef_bank #(
    .BITS  (FILTER_BITS),
    .TAPS  (FILTER_TAPS),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .widx   (widx),
    .wdata  (coef_data),
    .swap   (swap),
    .active (filter_coefficients)
  );
endmodule
